// File: rtl/rv64_pkg.sv
// Shared RV64 front-end constants and helpers.
package rv64_pkg;
    localparam int XLEN        = 64;
    localparam int ILEN        = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    // Redirect targets are forced onto an instruction boundary.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(INSTR_BYTES - 1);
    endfunction
endpackage

// File: rtl/fetch_ctrl_if.sv
// PC, redirect, instruction-memory and decode signals of the fetch controller.
interface fetch_ctrl_if;
    import rv64_pkg::*;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic            pc_en;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;
    logic            dec_valid;
    logic            dec_ready;
    logic [ILEN-1:0] dec_instr;
    logic [XLEN-1:0] dec_pc;

    modport master (
        input  pc, redirect_valid, redirect_pc, imem_req_ready,
               imem_rsp_valid, imem_rsp_data, dec_ready,
        output pc_next, pc_en, imem_req_valid, imem_req_addr,
               dec_valid, dec_instr, dec_pc
    );

    modport slave (
        output pc, redirect_valid, redirect_pc, imem_req_ready,
               imem_rsp_valid, imem_rsp_data, dec_ready,
        input  pc_next, pc_en, imem_req_valid, imem_req_addr,
               dec_valid, dec_instr, dec_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Circular fetch queue: entries are allocated at request time and filled in
// order by responses; filled entries always form a prefix starting at head.
module fetch_queue
    import rv64_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc,
    input  logic [XLEN-1:0]  alloc_pc,
    input  logic             fill,
    input  logic [ILEN-1:0]  fill_instr,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] unfilled,
    output logic             head_filled,
    output logic [XLEN-1:0]  head_pc,
    output logic [ILEN-1:0]  head_instr
);
    logic [XLEN-1:0]  pc_mem     [DEPTH];
    logic [ILEN-1:0]  instr_mem  [DEPTH];
    logic             filled_reg [DEPTH];
    logic [PTR_W-1:0] head_reg, tail_reg, fill_ptr_reg;
    logic [CNT_W-1:0] count_reg, unfilled_reg;
    logic             fill_en;

    assign fill_en = fill && (unfilled_reg != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            fill_ptr_reg <= '0;
            count_reg    <= '0;
            unfilled_reg <= '0;
        end else if (flush) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            fill_ptr_reg <= '0;
            count_reg    <= '0;
            unfilled_reg <= '0;
        end else begin
            if (alloc)   tail_reg     <= tail_reg + PTR_W'(1);
            if (fill_en) fill_ptr_reg <= fill_ptr_reg + PTR_W'(1);
            if (pop)     head_reg     <= head_reg + PTR_W'(1);
            count_reg    <= count_reg + CNT_W'(alloc) - CNT_W'(pop);
            unfilled_reg <= unfilled_reg + CNT_W'(alloc) - CNT_W'(fill_en);
        end
    end

    always_ff @(posedge clk) begin
        if (alloc && !flush)   pc_mem[tail_reg]        <= alloc_pc;
        if (fill_en && !flush) instr_mem[fill_ptr_reg] <= fill_instr;
    end

    // Fill and pop never target the same slot: fill hits the oldest unfilled
    // entry while pop only retires a filled head.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                filled_reg[gi] <= 1'b0;
            else if (flush)
                filled_reg[gi] <= 1'b0;
            else if (fill_en && fill_ptr_reg == PTR_W'(gi))
                filled_reg[gi] <= 1'b1;
            else if (pop && head_reg == PTR_W'(gi))
                filled_reg[gi] <= 1'b0;
        end
    end

    assign count       = count_reg;
    assign unfilled    = unfilled_reg;
    assign head_filled = filled_reg[head_reg];
    assign head_pc     = pc_mem[head_reg];
    assign head_instr  = instr_mem[head_reg];
endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: gates in-order memory requests, discards stale
// responses after redirects and feeds decode from the fetch queue.
module fetch_ctrl
    import rv64_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic          clk,
    input logic          rst,
    fetch_ctrl_if.master bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0] count, unfilled;
    logic [CNT_W-1:0] drop_cnt_reg, drop_cnt_next;
    logic [CNT_W:0]   in_flight;
    logic             head_filled, req_fire, rsp_drop, rsp_fill, pop;
    logic [XLEN-1:0]  head_pc;
    logic [ILEN-1:0]  head_instr;

    // Every outstanding memory transaction is either an unfilled entry or a
    // response still to be dropped; bounding their sum bounds drop_cnt too.
    assign in_flight = {1'b0, unfilled} + {1'b0, drop_cnt_reg};

    assign bus.imem_req_valid = !rst && !bus.redirect_valid
                                && (count < CNT_W'(DEPTH))
                                && (in_flight < (CNT_W + 1)'(DEPTH));
    assign bus.imem_req_addr  = bus.pc;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

    assign rsp_drop = bus.imem_rsp_valid && (drop_cnt_reg != '0);
    assign rsp_fill = bus.imem_rsp_valid && (drop_cnt_reg == '0);

    assign bus.dec_valid = head_filled && !bus.redirect_valid;
    assign bus.dec_pc    = head_pc;
    assign bus.dec_instr = head_instr;
    assign pop           = bus.dec_valid && bus.dec_ready;

    assign bus.pc_next = bus.redirect_valid ? align_pc(bus.redirect_pc)
                                            : bus.pc + XLEN'(INSTR_BYTES);
    assign bus.pc_en   = !rst && (bus.redirect_valid || req_fire);

    // On redirect, every request still unfilled after this cycle's response
    // becomes a stale response to discard.
    always_comb begin
        drop_cnt_next = drop_cnt_reg;
        if (rsp_drop)
            drop_cnt_next = drop_cnt_reg - CNT_W'(1);
        if (bus.redirect_valid)
            drop_cnt_next = drop_cnt_next + (unfilled - CNT_W'(rsp_fill));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            drop_cnt_reg <= '0;
        else
            drop_cnt_reg <= drop_cnt_next;
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .alloc       (req_fire),
        .alloc_pc    (bus.pc),
        .fill        (rsp_fill),
        .fill_instr  (bus.imem_rsp_data),
        .pop         (pop),
        .flush       (bus.redirect_valid),
        .count       (count),
        .unfilled    (unfilled),
        .head_filled (head_filled),
        .head_pc     (head_pc),
        .head_instr  (head_instr)
    );
endmodule
